dl_instr_sequencer: RTL and testbench

Data-link instruction sequencer for the UPDI target.
- Accepts received bytes from the PHY, decodes the opcode from cmd[7:5], and sequences the control/status register file through the csb0/web0/reg_addr interface.
- Runs LD/ST system-bus transfers, including REPEAT loops, and returns response bytes to the PHY.
- Sits between the UPDI PHY byte interface, the CS register file and the bus/pointer unit.

---
 rtl/dl_pkg.sv | 30 +++
 rtl/dl_repeat_counter.sv | 40 ++++
 rtl/dl_instr_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_dl_instr_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
// Shared types for the UPDI data-link instruction sequencer: opcodes, FSM states
// and the default acknowledge byte.
package dl_pkg;

    typedef enum logic [2:0] {
        OP_LDS  = 3'b000,
        OP_LD   = 3'b001,
        OP_STS  = 3'b010,
        OP_ST   = 3'b011,
        OP_LDCS = 3'b100,
        OP_REP  = 3'b101,
        OP_STCS = 3'b110,
        OP_KEY  = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CS_ACC    = 3'd1,
        S_CS_CAP    = 3'd2,
        S_TX        = 3'd3,
        S_WAIT_DATA = 3'd4,
        S_BUS       = 3'd5,
        S_ACK_TX    = 3'd6,
        S_WAIT_RPT  = 3'd7
    } state_e;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h40;
    localparam int         RPT_W_DEFAULT    = 8;

endpackage

// File: rtl/dl_repeat_counter.sv
// REPEAT iteration counter: clear beats load beats decrement; the decrement
// saturates at zero so a count of 255 yields 256 iterations without wrapping.
module dl_repeat_counter #(
    parameter int RPT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [RPT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [RPT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [RPT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(RPT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dl_instr_sequencer.sv
// UPDI data-link instruction sequencer: decodes PHY bytes, drives the CS register
// file and the system bus, and returns response bytes with REPEAT support.
module dl_instr_sequencer
    import dl_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEFAULT,
    parameter int         RPT_W    = RPT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             phy_break,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             csb0,
    output logic             web0,
    output logic [3:0]       reg_addr,
    output logic [7:0]       cs_wdata,
    input  logic [7:0]       cs_rdata,
    output logic             bus_req,
    output logic             bus_we,
    output logic [7:0]       bus_wdata,
    input  logic [7:0]       bus_rdata,
    input  logic             bus_ack,
    output logic             busy,
    output logic             err_opcode,
    output logic [2:0]       state_dbg,
    output logic [RPT_W-1:0] rpt_cnt_dbg
);

    state_e     state_q, state_d;
    opcode_e    op_q, op_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       err_q, err_d;
    logic       rpt_clr, rpt_load, rpt_dec, rpt_zero;

    dl_repeat_counter #(.RPT_W(RPT_W)) u_rpt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (rpt_clr),
        .load_i    (rpt_load),
        .load_val_i(RPT_W'(rx_data)),
        .dec_i     (rpt_dec),
        .cnt_o     (rpt_cnt_dbg),
        .zero_o    (rpt_zero)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        rpt_clr    = 1'b0;
        rpt_load   = 1'b0;
        rpt_dec    = 1'b0;

        // BREAK outranks any byte arriving in the same cycle.
        if (phy_break) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            rpt_clr    = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data[7:5])
                            OP_LDCS: begin
                                op_d    = OP_LDCS;
                                addr_d  = rx_data[3:0];
                                state_d = S_CS_ACC;
                            end
                            OP_STCS: begin
                                op_d    = OP_STCS;
                                addr_d  = rx_data[3:0];
                                state_d = S_WAIT_DATA;
                            end
                            OP_REP:  state_d = S_WAIT_RPT;
                            OP_LD: begin
                                op_d    = OP_LD;
                                state_d = S_BUS;
                            end
                            OP_ST: begin
                                op_d    = OP_ST;
                                state_d = S_WAIT_DATA;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                S_CS_ACC: state_d = (op_q == OP_STCS) ? S_IDLE : S_CS_CAP;
                S_CS_CAP: begin
                    tx_data_d  = cs_rdata;
                    tx_valid_d = 1'b1;
                    state_d    = S_TX;
                end
                S_TX: begin
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                        if (op_q == OP_LD) begin
                            if (!rpt_zero) begin
                                rpt_dec = 1'b1;
                                state_d = S_BUS;
                            end else begin
                                rpt_clr = 1'b1;
                            end
                        end
                    end
                end
                S_WAIT_DATA: begin
                    if (rx_valid) begin
                        data_d  = rx_data;
                        state_d = (op_q == OP_STCS) ? S_CS_ACC : S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus_ack) begin
                        tx_valid_d = 1'b1;
                        if (op_q == OP_ST) begin
                            tx_data_d = ACK_BYTE;
                            state_d   = S_ACK_TX;
                        end else begin
                            tx_data_d = bus_rdata;
                            state_d   = S_TX;
                        end
                    end
                end
                S_ACK_TX: begin
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        if (!rpt_zero) begin
                            rpt_dec = 1'b1;
                            state_d = S_WAIT_DATA;
                        end else begin
                            rpt_clr = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_WAIT_RPT: begin
                    if (rx_valid) begin
                        rpt_load = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_LDS;
            addr_q     <= 4'h0;
            data_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    // Register-file strobes are decoded from state so they can only be low in CS_ACC.
    assign csb0       = (state_q != S_CS_ACC);
    assign web0       = !((state_q == S_CS_ACC) && (op_q == OP_STCS));
    assign reg_addr   = addr_q;
    assign cs_wdata   = data_q;
    assign bus_req    = (state_q == S_BUS);
    assign bus_we     = (state_q == S_BUS) && (op_q == OP_ST);
    assign bus_wdata  = data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign busy       = (state_q != S_IDLE);
    assign err_opcode = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_dl_instr_sequencer.sv
// Directed scoreboard bench for dl_instr_sequencer: expected tx bytes, CS accesses
// and bus transfers are queued at issue time and checked by a separate monitor.
module tb_dl_instr_sequencer;
  import dl_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       phy_break;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       csb0;
  logic       web0;
  logic [3:0] reg_addr;
  logic [7:0] cs_wdata;
  logic [7:0] cs_rdata;
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       busy;
  logic       err_opcode;
  logic [2:0] state_dbg;
  logic [7:0] rpt_cnt_dbg;

  dl_instr_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .phy_break  (phy_break),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .csb0       (csb0),
    .web0       (web0),
    .reg_addr   (reg_addr),
    .cs_wdata   (cs_wdata),
    .cs_rdata   (cs_rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .busy       (busy),
    .err_opcode (err_opcode),
    .state_dbg  (state_dbg),
    .rpt_cnt_dbg(rpt_cnt_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [7:0]  tx_exp_q[$];
  logic [12:0] cs_exp_q[$];   // {web0, reg_addr, wdata (0 for reads)}
  logic [8:0]  bus_exp_q[$];  // {we, wdata (0 for reads)}
  logic [7:0]  rd_q[$];       // data the bus model returns for reads
  int n_cmp = 0;
  int n_err = 0;
  int err_seen = 0;
  int bus_delay = 0;
  int bus_wait = 0;
  logic stalled;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [15:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // ---------------- responders ----------------
  initial begin : tx_model
    tx_ready = 1'b0;
    stalled  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !tx_valid) begin
        tx_ready = 1'b0;
        stalled  = 1'b0;
      end else if (!stalled) begin
        stalled = 1'b1;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  initial begin : bus_model
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (rst_n && bus_req) begin
        bus_wait++;
        if (bus_wait > bus_delay) begin
          bus_ack  = 1'b1;
          bus_wait = 0;
          if (!bus_we && rd_q.size() > 0) bus_rdata = rd_q.pop_front();
        end
      end else begin
        bus_wait = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [7:0]  e8;
    logic [12:0] e13;
    logic [8:0]  e9;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_valid && tx_ready) begin
          if (tx_exp_q.size() == 0) unexpected("tx_byte", {8'h00, tx_data});
          else begin
            e8 = tx_exp_q.pop_front();
            check("tx_byte", {8'h00, tx_data}, {8'h00, e8});
          end
        end
        if (!csb0) begin
          if (cs_exp_q.size() == 0) unexpected("cs_access", {3'b000, web0, reg_addr, cs_wdata});
          else begin
            e13 = cs_exp_q.pop_front();
            check("cs_access", {3'b000, web0, reg_addr, (web0 ? 8'h00 : cs_wdata)}, {3'b000, e13});
          end
        end
        if (bus_req && bus_ack) begin
          if (bus_exp_q.size() == 0) unexpected("bus_xfer", {7'h00, bus_we, bus_wdata});
          else begin
            e9 = bus_exp_q.pop_front();
            check("bus_xfer", {7'h00, bus_we, (bus_we ? bus_wdata : 8'h00)}, {7'h00, e9});
          end
        end
        if (err_opcode) err_seen++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_in_state(input logic [7:0] b, input logic [2:0] st);
    int n = 0;
    while (state_dbg !== st && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) unexpected("send_wait_state", {13'h0, state_dbg});
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((busy || tx_exp_q.size() != 0 || cs_exp_q.size() != 0 || bus_exp_q.size() != 0)
           && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) unexpected("wait_idle_timeout", {13'h0, state_dbg});
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    phy_break = 1'b0;
    cs_rdata  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_csb0_web0", {14'h0, csb0, web0}, 16'h0003);
    check("rst_reg_addr", {12'h0, reg_addr}, 16'h0000);
    check("rst_cs_wdata", {8'h0, cs_wdata}, 16'h0000);
    check("rst_tx", {7'h0, tx_valid, tx_data}, 16'h0000);
    check("rst_bus", {6'h0, bus_req, bus_we, bus_wdata}, 16'h0000);
    check("rst_busy_err", {14'h0, busy, err_opcode}, 16'h0000);
    check("rst_rpt_cnt", {8'h0, rpt_cnt_dbg}, 16'h0000);

    // LDCS reg 3
    cs_rdata = 8'h5A;
    cs_exp_q.push_back({1'b1, 4'd3, 8'h00});
    tx_exp_q.push_back(8'h5A);
    send_in_state(8'h83, S_IDLE);
    check("ldcs_t1_strobes", {11'h0, csb0, web0, reg_addr}, {11'h0, 1'b0, 1'b1, 4'd3});
    wait_idle(50);
    check("ldcs_busy_done", {15'h0, busy}, 16'h0000);

    // STCS reg 2 <= 0x1F, no response byte
    cs_exp_q.push_back({1'b0, 4'd2, 8'h1F});
    send_in_state(8'hC2, S_IDLE);
    send_in_state(8'h1F, S_WAIT_DATA);
    check("stcs_strobes", {10'h0, csb0, web0, reg_addr}, {10'h0, 1'b0, 1'b0, 4'd2});
    wait_idle(50);

    // REPEAT 2 + ST: three writes, three ACKs
    bus_delay = 0;
    send_in_state(8'hA0, S_IDLE);
    send_in_state(8'h02, S_WAIT_RPT);
    check("rpt_loaded_2", {8'h0, rpt_cnt_dbg}, 16'h0002);
    send_in_state(8'h60, S_IDLE);
    foreach (tx_exp_q[i]) unexpected("stale_tx_q", {8'h0, tx_exp_q[i]});
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d;
      d = 8'h11 * (i + 1);
      bus_exp_q.push_back({1'b1, d});
      tx_exp_q.push_back(8'h40);
      send_in_state(d, S_WAIT_DATA);
    end
    wait_idle(100);
    check("rpt_st_end_cnt", {8'h0, rpt_cnt_dbg}, 16'h0000);

    // REPEAT reload (5 then 1) + LD with 5-cycle bus delay, stray byte in BUS ignored
    bus_delay = 5;
    send_in_state(8'hA0, S_IDLE);
    send_in_state(8'h05, S_WAIT_RPT);
    send_in_state(8'hA0, S_IDLE);
    send_in_state(8'h01, S_WAIT_RPT);
    check("rpt_reloaded_1", {8'h0, rpt_cnt_dbg}, 16'h0001);
    rd_q.push_back(8'hA5);
    rd_q.push_back(8'h3C);
    bus_exp_q.push_back({1'b0, 8'h00});
    bus_exp_q.push_back({1'b0, 8'h00});
    tx_exp_q.push_back(8'hA5);
    tx_exp_q.push_back(8'h3C);
    send_in_state(8'h20, S_IDLE);
    check("ld_bus_req_we", {14'h0, bus_req, bus_we}, 16'h0002);
    send_in_state(8'h83, S_BUS);
    check("ld_req_held", {14'h0, bus_req, bus_ack}, 16'h0002);
    wait_idle(200);
    check("rpt_ld_end_cnt", {8'h0, rpt_cnt_dbg}, 16'h0000);

    // BREAK during the second of three ST iterations
    bus_delay = 3;
    send_in_state(8'hA0, S_IDLE);
    send_in_state(8'h02, S_WAIT_RPT);
    send_in_state(8'h60, S_IDLE);
    bus_exp_q.push_back({1'b1, 8'h11});
    tx_exp_q.push_back(8'h40);
    send_in_state(8'h11, S_WAIT_DATA);
    send_in_state(8'h22, S_WAIT_DATA);
    check("brk_in_bus", {13'h0, state_dbg}, {13'h0, S_BUS});
    phy_break = 1'b1;
    @(negedge clk);
    phy_break = 1'b0;
    check("brk_state_idle", {13'h0, state_dbg}, {13'h0, S_IDLE});
    check("brk_outputs", {13'h0, bus_req, tx_valid, busy}, 16'h0000);
    check("brk_rpt_cnt", {8'h0, rpt_cnt_dbg}, 16'h0000);
    repeat (20) @(negedge clk);
    check("brk_no_more_tx", {13'h0, state_dbg}, {13'h0, S_IDLE});
    cs_rdata = 8'h77;
    cs_exp_q.push_back({1'b1, 4'd3, 8'h00});
    tx_exp_q.push_back(8'h77);
    send_in_state(8'h83, S_IDLE);
    wait_idle(50);

    // unsupported opcodes: one pulse each, nothing else moves
    begin
      int base;
      base = err_seen;
      send_in_state(8'h00, S_IDLE);
      check("err_lds_busy", {15'h0, busy}, 16'h0000);
      send_in_state(8'h40, S_IDLE);
      send_in_state(8'hE0, S_IDLE);
      repeat (3) @(negedge clk);
      check("err_pulse_count", 16'(err_seen - base), 16'd3);
      check("err_idle", {13'h0, state_dbg}, {13'h0, S_IDLE});
    end

    // async reset in the middle of an LD
    bus_delay = 8;
    send_in_state(8'h20, S_IDLE);
    check("arst_in_bus", {15'h0, bus_req}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bus", {6'h0, bus_req, bus_we, bus_wdata}, 16'h0000);
    check("arst_tx", {7'h0, tx_valid, tx_data}, 16'h0000);
    check("arst_cs", {10'h0, csb0, web0, reg_addr}, 16'h0030);
    check("arst_busy", {13'h0, state_dbg}, {13'h0, S_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    rd_q.delete();
    repeat (4) @(negedge clk);
    check("arst_stays_idle", {14'h0, busy, bus_req}, 16'h0000);

    check("end_tx_q_empty", 16'(tx_exp_q.size()), 16'd0);
    check("end_cs_q_empty", 16'(cs_exp_q.size()), 16'd0);
    check("end_bus_q_empty", 16'(bus_exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
